// File: rtl/rtc_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_ctrl
// Description : Transaction engine for the RTC multiplexed address/data bus.
//               One read or write per request: an address phase, then a data
//               phase, with registered strobes and bus enable.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_ctrl #(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       RW,
  inout  wire  [7:0] Dato_sal
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_SET = 3'd1,
    A_STB = 3'd2,
    A_HLD = 3'd3,
    D_SET = 3'd4,
    D_STB = 3'd5,
    D_HLD = 3'd6,
    RECOV = 3'd7
  } state_t;

  localparam logic [7:0] C_PHASE_LAST = 8'(PHASE_CYC - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_cnt;
  logic       w_phase_end;
  logic       w_accept;

  logic       r_wr;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       w_wr_eff;
  logic [7:0] w_addr_eff;
  logic [7:0] w_wdata_eff;

  logic       w_ad_nxt;
  logic       w_cs_nxt;
  logic       w_rd_nxt;
  logic       w_rw_nxt;
  logic       w_oe_nxt;
  logic [7:0] w_bus_nxt;
  logic       r_oe;
  logic [7:0] r_bus_out;

  assign w_phase_end = (r_cnt == C_PHASE_LAST);
  assign w_accept    = (r_state == IDLE) && start;

  // Pin values are derived from the state being entered, so the request
  // fields must bypass the latch on the accepting edge.
  assign w_wr_eff    = w_accept ? wr    : r_wr;
  assign w_addr_eff  = w_accept ? addr  : r_addr;
  assign w_wdata_eff = w_accept ? wdata : r_wdata;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)       w_next_state = A_SET;
      A_SET:   if (w_phase_end) w_next_state = A_STB;
      A_STB:   if (w_phase_end) w_next_state = A_HLD;
      A_HLD:   if (w_phase_end) w_next_state = D_SET;
      D_SET:   if (w_phase_end) w_next_state = D_STB;
      D_STB:   if (w_phase_end) w_next_state = D_HLD;
      D_HLD:   if (w_phase_end) w_next_state = RECOV;
      RECOV:   if (w_phase_end) w_next_state = IDLE;
      default:                  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ad_nxt  = 1'b1;
    w_cs_nxt  = 1'b1;
    w_rd_nxt  = 1'b1;
    w_rw_nxt  = 1'b1;
    w_oe_nxt  = 1'b0;
    w_bus_nxt = w_addr_eff;
    case (w_next_state)
      A_SET: begin
        w_ad_nxt = 1'b0;
        w_oe_nxt = 1'b1;
      end
      A_STB: begin
        w_ad_nxt = 1'b0;
        w_cs_nxt = 1'b0;
        w_rw_nxt = 1'b0;
        w_oe_nxt = 1'b1;
      end
      A_HLD: begin
        w_ad_nxt = 1'b0;
        w_oe_nxt = 1'b1;
      end
      D_SET, D_HLD: begin
        w_oe_nxt  = w_wr_eff;
        w_bus_nxt = w_wdata_eff;
      end
      D_STB: begin
        w_cs_nxt  = 1'b0;
        w_rw_nxt  = ~w_wr_eff;
        w_rd_nxt  = w_wr_eff;
        w_oe_nxt  = w_wr_eff;
        w_bus_nxt = w_wdata_eff;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_wr      <= 1'b0;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      AD        <= 1'b1;
      CS        <= 1'b1;
      RD        <= 1'b1;
      RW        <= 1'b1;
      r_oe      <= 1'b0;
      r_bus_out <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'h00;
    end else begin
      r_state <= w_next_state;
      // Counter restarts on every state entry and idles at zero.
      if ((w_next_state != r_state) || (r_state == IDLE)) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_accept) begin
        r_wr    <= wr;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      AD        <= w_ad_nxt;
      CS        <= w_cs_nxt;
      RD        <= w_rd_nxt;
      RW        <= w_rw_nxt;
      r_oe      <= w_oe_nxt;
      r_bus_out <= w_bus_nxt;
      busy      <= (w_next_state != IDLE);
      done      <= (r_state == RECOV) && w_phase_end;
      if ((r_state == D_STB) && w_phase_end && !r_wr) begin
        rdata <= Dato_sal;
      end
    end
  end

  assign Dato_sal = r_oe ? r_bus_out : 8'hzz;

endmodule
`default_nettype wire

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Low-level transaction engine between the time-keeping/PicoBlaze logic and the external RTC chip's multiplexed address/data bus.
- Accepts one read or write request at a time, as an 8-bit register address plus 8-bit data.
- Sequences the active-low AD, CS, RD and RW strobes and the bidirectional Dato_sal bus through a fixed address phase, then a data phase.
- Returns read data with a one-cycle done pulse. Sits directly downstream of the register-access sequencer and drives the board pins.

Parameters:
- PHASE_CYC, 4, clk cycles per bus sub-phase; legal range 1..255; 4 gives 40 ns at 100 MHz.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- wr  in  1  request type: 1 = write, 0 = read. Latched with start.
- addr  in  8  RTC register address. Latched with start.
- wdata  in  8  write data. Latched with start.
- rdata  out  8  last read result; holds until the next read completes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transaction completes.
- AD  out  1  address/data select to RTC: 0 = address phase, 1 = data phase.
- CS  out  1  chip select, active low.
- RD  out  1  read strobe, active low.
- RW  out  1  write strobe, active low.
- Dato_sal  inout  8  RTC multiplexed bus; tri-stated (8'hZZ) whenever this block is not driving it.

Behaviour:
- Reset (reset=0 at a rising edge):
  - State returns to IDLE and the phase counter clears.
  - AD=1, CS=1, RD=1, RW=1; bus released; busy=0; done=0; rdata=8'h00.
  - Applies mid-transaction with no completion and no done pulse.
- All pin outputs and the bus output-enable are registered; no combinational paths from inputs to pins.
- FSM states: IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, RECOV.
  - Every non-IDLE state lasts exactly PHASE_CYC cycles, timed by a phase counter that restarts on each state entry.
  - Sequence is fixed: A_SET -> A_STB -> A_HLD -> D_SET -> D_STB -> D_HLD -> RECOV -> IDLE.
- IDLE: AD=1, CS=1, RD=1, RW=1; bus released.
  - If start=1 on edge k: latch wr/addr/wdata and enter A_SET.
  - start while busy is ignored and not queued.
- A_SET: AD=0; bus drives the latched addr; CS=RD=RW=1.
- A_STB: AD=0; bus drives addr; CS=0; RW=0 (address latch pulse); RD=1.
- A_HLD: AD=0; bus drives addr; CS=1; RW=1.
- D_SET: AD=1; CS=RD=RW=1.
  - Write: bus drives wdata.
  - Read: bus released.
- D_STB: AD=1; CS=0.
  - Write: RW=0, RD=1, bus drives wdata.
  - Read: RD=0, RW=1, bus released. rdata captures Dato_sal on the last cycle of D_STB, i.e. the edge that exits the state.
- D_HLD: CS=RD=RW=1; AD=1.
  - Write: bus still drives wdata.
  - Read: bus released.
- RECOV: all strobes high; bus released. On exit, enter IDLE and assert done for exactly one cycle.
- Timing:
  - Request sampled at edge k.
  - A_SET occupies cycles k+1..k+PHASE_CYC.
  - done is high in cycle k+7*PHASE_CYC+1.
  - busy is high in cycles k+1..k+7*PHASE_CYC and low in the done cycle.
- Back-to-back: start asserted in the same cycle as done is accepted. The next A_SET begins the following cycle, so IDLE lasts a minimum of 1 cycle.
- Interlocks:
  - CS=0 is never coincident with a change of AD or of the bus direction.
  - RD and RW are never both low.
- rdata is unchanged by write transactions.

Test Plan:
- Reset hold: reset=0 for 3 cycles with start=1 -> AD=CS=RD=RW=1, Dato_sal=ZZ, busy=0, done=0, rdata=00.
- Write, PHASE_CYC=2, start with wr=1, addr=8'h21, wdata=8'h45:
  - AD=0 with bus=21 for cycles 1-6; CS=RW=0 in cycles 3-4.
  - AD=1 in cycles 7-14; bus=45 in cycles 7-12; CS=RW=0 in cycles 9-10.
  - done=1 only in cycle 15; RD never low.
- Read, PHASE_CYC=2, wr=0, addr=8'h24, model drives 8'h59 while RD=0 -> bus released in cycles 7-15; RD=0 in cycles 9-10; rdata=59 from cycle 11; done in cycle 15; RW low only in cycles 3-4.
- Busy collision: second start at cycle 5 of a transaction -> ignored; exactly one done; latched addr/wdata unchanged mid-transaction.
- Back-to-back: start held high through done -> second A_SET begins the cycle after done; the pin checker confirms no CS low across an AD edge.
- Mid-op reset: reset=0 during D_STB of a read -> next cycle all strobes high, bus released, no done pulse, rdata=00; a following read returns its data correctly.
